// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
// Optional build macro used by the slice: AUTO_REPEAT_EN (auto-repeat pulses).
package debounce_pkg;

  // Per-channel event bundle produced by debounce_channel.
  typedef struct packed {
    logic stable;
    logic pressed;
    logic released;
    logic long_press;
    logic repeat_pulse;
  } btn_evt_t;

  // Counter width for a count range of x: $clog2(x), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned x);
    int unsigned w;
    w = $clog2(x);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single button channel: 2-flop synchroniser, polarity normalisation,
// debounce, registered edge detect, long-press detect and (when the
// AUTO_REPEAT_EN macro is defined) auto-repeat generation.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000
) (
  input  logic     clk_12m,
  input  logic     rst,
  input  logic     btn_in,
  output btn_evt_t evt
);

  localparam int unsigned          DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned          HOLD_W   = cnt_width(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  logic              s1;
  logic              s2;
  logic [DB_W-1:0]   db_cnt;
  logic              stable;
  logic              prev_stable;
  logic              pressed;
  logic              released;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_press;
  logic              repeat_pulse;

  // Synchronise the raw level and fold in the pressed polarity.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in ^ ACTIVE_LOW;
      s2 <= s1;
    end
  end

  // Flip the debounced level only after an unbroken run of mismatches.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      db_cnt <= '0;
      stable <= 1'b0;
    end else if (s2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Registered edge detect on the debounced level.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      prev_stable <= 1'b0;
      pressed     <= 1'b0;
      released    <= 1'b0;
    end else begin
      prev_stable <= stable;
      pressed     <= stable & ~prev_stable;
      released    <= ~stable & prev_stable;
    end
  end

  // Count hold time, saturating so long_press fires once per hold.
  always_ff @(posedge clk_12m) begin
    if (rst || !stable) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      long_press <= (hold_cnt == HOLD_PRE);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned       REP_W    = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic             rep_active;
  logic [REP_W-1:0] rep_cnt;

  // Repeat period starts on the same edge that raises long_press; the
  // registered stable gate suppresses any pulse once the release lands.
  always_ff @(posedge clk_12m) begin
    if (rst || !stable) begin
      rep_active   <= 1'b0;
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else if (hold_cnt == HOLD_PRE) begin
      rep_active   <= 1'b1;
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else if (rep_active) begin
      if (rep_cnt == REP_LAST) begin
        rep_cnt      <= '0;
        repeat_pulse <= 1'b1;
      end else begin
        rep_cnt      <= rep_cnt + 1'b1;
        repeat_pulse <= 1'b0;
      end
    end else begin
      repeat_pulse <= 1'b0;
    end
  end
`else
  // Auto-repeat compiled out: no counter, output held low.
  assign repeat_pulse = 1'b0;
`endif

  // Bundle the channel state for the top level.
  always_comb begin
    evt              = '0;
    evt.stable       = stable;
    evt.pressed      = pressed;
    evt.released     = released;
    evt.long_press   = long_press;
    evt.repeat_pulse = repeat_pulse;
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button conditioner: one debounce_channel per button, an OR of
// the debounced levels and a shared 8-bit wrapping press counter.
// Optional build macro: AUTO_REPEAT_EN enables per-channel auto-repeat.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000
) (
  input  logic                clk_12m,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] stable,
  output logic [NUM_BTNS-1:0] pressed,
  output logic [NUM_BTNS-1:0] released,
  output logic [NUM_BTNS-1:0] long_press,
  output logic [NUM_BTNS-1:0] repeat_pulse,
  output logic                any_stable,
  output logic [7:0]          press_count
);

  btn_evt_t   evt [NUM_BTNS];
  logic [7:0] press_add;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk_12m (clk_12m),
      .rst     (rst),
      .btn_in  (btn_in[i]),
      .evt     (evt[i])
    );
  end

  // Unpack per-channel events into the flat output vectors.
  always_comb begin
    stable       = '0;
    pressed      = '0;
    released     = '0;
    long_press   = '0;
    repeat_pulse = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      stable[i]       = evt[i].stable;
      pressed[i]      = evt[i].pressed;
      released[i]     = evt[i].released;
      long_press[i]   = evt[i].long_press;
      repeat_pulse[i] = evt[i].repeat_pulse;
    end
  end

  assign any_stable = |stable;

  // Popcount of this cycle's press pulses, truncated to the counter width.
  always_comb begin
    press_add = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      press_add = press_add + 8'(pressed[i]);
    end
  end

  // Shared press counter, wraps silently modulo 256.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      press_count <= '0;
    end else begin
      press_count <= press_count + press_add;
    end
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Self-checking bench for multi_button_debouncer: an active-high instance and
// an active-low instance, a cycle-level reference model, and directed scenarios.
module tb_multi_button_debouncer;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic         clk_12m = 1'b0;
  logic         rst     = 1'b1;
  logic [N-1:0] btn_a   = '0;
  logic [N-1:0] btn_b   = '1;

  logic [N-1:0] a_stable, a_pressed, a_released, a_long, a_repeat;
  logic [N-1:0] b_stable, b_pressed, b_released, b_long, b_repeat;
  logic         a_any, b_any;
  logic [7:0]   a_count, b_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  multi_button_debouncer #(
    .NUM_BTNS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0),
    .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk_12m(clk_12m), .rst(rst), .btn_in(btn_a),
    .stable(a_stable), .pressed(a_pressed), .released(a_released),
    .long_press(a_long), .repeat_pulse(a_repeat),
    .any_stable(a_any), .press_count(a_count)
  );

  multi_button_debouncer #(
    .NUM_BTNS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1),
    .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut_al (
    .clk_12m(clk_12m), .rst(rst), .btn_in(btn_b),
    .stable(b_stable), .pressed(b_pressed), .released(b_released),
    .long_press(b_long), .repeat_pulse(b_repeat),
    .any_stable(b_any), .press_count(b_count)
  );

  initial forever #5 clk_12m = ~clk_12m;

  // Reference model, index 0 = active-high DUT, 1 = active-low DUT.
  logic [31:0]  m_hist [2][N];   // pressed-polarity samples, bit0 = newest
  int           m_rise [2][N];   // edge at which stable last rose
  logic [N-1:0] m_st [2], m_st_old [2], m_pr [2], m_rl [2], m_lp [2], m_rp [2];
  logic [7:0]   m_cnt [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Stable flips once the D samples taken 2..D+1 edges ago all disagree with it;
  // the pulses and counts follow from edge indices relative to the last rise.
  task automatic model_step();
    logic       raw, flip;
    int         age;
    logic [7:0] add;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_st[d] = '0; m_st_old[d] = '0; m_pr[d] = '0; m_rl[d] = '0;
        m_lp[d] = '0; m_rp[d] = '0; m_cnt[d] = '0;
        for (int c = 0; c < N; c++) begin
          m_hist[d][c] = '0;
          m_rise[d][c] = 0;
        end
      end else begin
        add = 8'($countones(m_pr[d]));
        m_cnt[d] = m_cnt[d] + add;
        for (int c = 0; c < N; c++) begin
          raw = (d == 0) ? btn_a[c] : ~btn_b[c];
          age = cyc - m_rise[d][c];
          m_pr[d][c] = m_st[d][c] & ~m_st_old[d][c];
          m_rl[d][c] = ~m_st[d][c] & m_st_old[d][c];
          m_lp[d][c] = m_st[d][c] && (age == L);
`ifdef AUTO_REPEAT_EN
          m_rp[d][c] = m_st[d][c] && (age > L) && (((age - L) % R) == 0);
`else
          m_rp[d][c] = 1'b0;
`endif
          flip = 1'b1;
          for (int i = 1; i <= D; i++) begin
            if (m_hist[d][c][i] == m_st[d][c]) flip = 1'b0;
          end
          m_st_old[d][c] = m_st[d][c];
          if (flip) begin
            m_st[d][c] = ~m_st[d][c];
            if (m_st[d][c]) m_rise[d][c] = cyc;
          end
          m_hist[d][c] = {m_hist[d][c][30:0], raw};
        end
      end
    end
    started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk_12m);
    model_step();
  end

  // Every-cycle comparison of both DUTs against the model.
  initial forever begin
    @(negedge clk_12m);
    if (started) begin
      chk("a.stable",   8'(a_stable),   8'(m_st[0]));
      chk("a.pressed",  8'(a_pressed),  8'(m_pr[0]));
      chk("a.released", 8'(a_released), 8'(m_rl[0]));
      chk("a.long",     8'(a_long),     8'(m_lp[0]));
      chk("a.repeat",   8'(a_repeat),   8'(m_rp[0]));
      chk("a.any",      8'(a_any),      8'(|m_st[0]));
      chk("a.count",    a_count,        m_cnt[0]);
      chk("b.stable",   8'(b_stable),   8'(m_st[1]));
      chk("b.pressed",  8'(b_pressed),  8'(m_pr[1]));
      chk("b.released", 8'(b_released), 8'(m_rl[1]));
      chk("b.long",     8'(b_long),     8'(m_lp[1]));
      chk("b.repeat",   8'(b_repeat),   8'(m_rp[1]));
      chk("b.any",      8'(b_any),      8'(|m_st[1]));
      chk("b.count",    b_count,        m_cnt[1]);
    end
  end

  task automatic wait_edge(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk_12m);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_edge: reached edge %0d expected %0d", cyc, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int long_n, long_at, rep_n, fall_at, rel_at;
    int rep_at [4];

    repeat (3) @(negedge clk_12m);
    chk("reset.a_stable", 8'(a_stable), 8'h00);
    chk("reset.a_count",  a_count,      8'h00);
    chk("reset.b_stable", 8'(b_stable), 8'h00);
    chk("reset.b_any",    8'(b_any),    8'h00);
    rst = 1'b0;

    // 1: single press latency
    btn_a[0] = 1'b1; k = cyc + 1;
    wait_edge(k + 4); chk("t1.stable_early", 8'(a_stable[0]), 8'h0);
    wait_edge(k + 5); chk("t1.stable", 8'(a_stable[0]), 8'h1);
                      chk("t1.pressed_early", 8'(a_pressed[0]), 8'h0);
    wait_edge(k + 6); chk("t1.pressed", 8'(a_pressed[0]), 8'h1);
    wait_edge(k + 7); chk("t1.pressed_end", 8'(a_pressed[0]), 8'h0);
                      chk("t1.count", a_count, 8'd1);
    btn_a[0] = 1'b0;
    repeat (8) @(negedge clk_12m);

    // 5: active-low instance
    btn_b[3] = 1'b0; k = cyc + 1;
    wait_edge(k + 5); chk("t5.stable", 8'(b_stable[3]), 8'h1);
    wait_edge(k + 6); chk("t5.pressed", 8'(b_pressed[3]), 8'h1);
    btn_b[3] = 1'b1;
    repeat (8) @(negedge clk_12m);

    // 2: glitch bursts never qualify
    for (int b = 1; b <= 3; b++) begin
      btn_a[1] = 1'b1;
      repeat (b) @(negedge clk_12m);
      btn_a[1] = 1'b0;
      @(negedge clk_12m);
    end
    repeat (10) @(negedge clk_12m);
    chk("t2.count",  a_count, 8'd1);
    chk("t2.stable", 8'(a_stable[1]), 8'h0);

    // 3: long press, repeats, release
    long_n = 0; long_at = -1; rep_n = 0; fall_at = -1; rel_at = -1;
    btn_a[2] = 1'b1; k = cyc + 1;
    for (int e = k + 1; e <= k + 50; e++) begin
      wait_edge(e);
      if (a_long[2]) begin long_n++; long_at = cyc; end
      if (a_repeat[2]) begin
        if (rep_n < 4) rep_at[rep_n] = cyc;
        rep_n++;
      end
      if (a_released[2] && rel_at < 0) rel_at = cyc;
      if (!a_stable[2] && fall_at < 0 && e > k + 5) fall_at = cyc;
      if (e == k + 35) btn_a[2] = 1'b0;
    end
    chk("t3.long_count", 8'(long_n), 8'd1);
    chk("t3.long_edge",  8'(long_at - k), 8'd25);
    chk("t3.fall_edge",  8'(fall_at - k), 8'd41);
    chk("t3.rel_edge",   8'(rel_at - k), 8'd42);
`ifdef AUTO_REPEAT_EN
    chk("t3.repeat_count", 8'(rep_n), 8'd3);
    chk("t3.repeat1", 8'(rep_at[0] - long_at), 8'd5);
    chk("t3.repeat2", 8'(rep_at[1] - long_at), 8'd10);
    chk("t3.repeat3", 8'(rep_at[2] - long_at), 8'd15);
`else
    chk("t3.repeat_count", 8'(rep_n), 8'd0);
`endif

    // 4: preload 254 presses, then 4 simultaneous -> wrap to 2
    rst = 1'b1;
    repeat (2) @(negedge clk_12m);
    rst = 1'b0;
    for (int p = 0; p < 64; p++) begin
      btn_a = (p == 63) ? 4'b0011 : 4'b1111;
      repeat (7) @(negedge clk_12m);
      btn_a = '0;
      repeat (7) @(negedge clk_12m);
    end
    chk("t4.preload", a_count, 8'd254);
    btn_a = '1; k = cyc + 1;
    wait_edge(k + 5); chk("t4.any", 8'(a_any), 8'h1);
    wait_edge(k + 6); chk("t4.pressed", 8'(a_pressed), 8'h0f);
    wait_edge(k + 7); chk("t4.pressed_end", 8'(a_pressed), 8'h00);
                      chk("t4.wrap", a_count, 8'd2);
    btn_a = '0;
    repeat (10) @(negedge clk_12m);

    // 6: reset mid-hold (ch2) and mid-debounce (ch0)
    btn_a[2] = 1'b1;
    repeat (12) @(negedge clk_12m);
    btn_a[0] = 1'b1; k = cyc + 1;
    wait_edge(k + 3); rst = 1'b1;
    wait_edge(k + 4);
    chk("t6.rst_stable",   8'(a_stable),   8'h00);
    chk("t6.rst_pressed",  8'(a_pressed),  8'h00);
    chk("t6.rst_released", 8'(a_released), 8'h00);
    chk("t6.rst_count",    a_count,        8'h00);
    chk("t6.rst_any",      8'(a_any),      8'h00);
    rst = 1'b0;
    wait_edge(k + 9);  chk("t6.stable_early",  8'(a_stable),  8'h00);
    wait_edge(k + 10); chk("t6.stable",        8'(a_stable),  8'h05);
                       chk("t6.pressed_early", 8'(a_pressed), 8'h00);
    wait_edge(k + 11); chk("t6.pressed",       8'(a_pressed), 8'h05);
    wait_edge(k + 12); chk("t6.count",         a_count,       8'd2);
    btn_a = '0;
    repeat (10) @(negedge clk_12m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
